uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1_250_000: the number of owner-idle cycles in LOCKED that forces release (10 ms at 125 MHz); legal range 2..2^24.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req0_data, input, 8 bits: requester 0 byte.
REQ-005 SHALL have port req0_valid, input, 1 bit: requester 0 byte valid.
REQ-006 SHALL have port req0_last, input, 1 bit: requester 0 byte is the final byte of its message.
REQ-007 SHALL have port req0_ready, output, 1 bit: requester 0 byte accepted this cycle when valid.
REQ-008 SHALL have ports req1_data, req1_valid, req1_last and req1_ready, with the same directions, widths and meanings as the requester 0 ports.
REQ-009 SHALL have port tx_data, output, 8 bits: byte to the UART transmitter.
REQ-010 SHALL have port tx_valid, output, 1 bit: tx_data valid.
REQ-011 SHALL have port tx_ready, input, 1 bit: the UART transmitter can accept a byte.
REQ-012 SHALL have port grant, output, 2 bits: one-hot current owner; 00 when no requester owns the transmitter.
REQ-013 SHALL have port timeout_pulse, output, 1 bit: one-cycle strobe when ownership is force-released.

Function
REQ-014 SHALL implement two states: IDLE (no owner) and LOCKED (owner held in a 1-bit owner register).
REQ-015 SHALL keep a 1-bit priority pointer naming the requester preferred on a tie.
REQ-016 In IDLE, if any reqN_valid=1, SHALL go to LOCKED on the next edge with owner = the sole valid requester, or the pointer's requester if both are valid.
REQ-017 In IDLE, SHALL drive tx_valid=0, both reqN_ready=0 and grant=00.
REQ-018 In LOCKED, SHALL drive tx_data, tx_valid and grant combinationally from the owner's data and valid; no extra register stage.
REQ-019 In LOCKED, SHALL drive the owner's ready = tx_ready and the non-owner's ready = 0.
REQ-020 A transfer SHALL be a cycle with tx_valid=1 and tx_ready=1; exactly one byte per transfer; no byte is duplicated or dropped.
REQ-021 Latency SHALL be one cycle: a valid asserted in IDLE at cycle N can first transfer at cycle N+1.
REQ-022 A transfer with owner last=1 SHALL return the block to IDLE on the next edge and set the pointer to the other requester (round-robin).
REQ-023 Multi-byte messages SHALL never interleave; the non-owner waits until release regardless of its valid.
REQ-024 The idle counter SHALL clear on entry to LOCKED and on every transfer.
REQ-025 The idle counter SHALL increment on each LOCKED cycle in which the owner's valid=0, and SHALL hold (no increment) while the owner is valid but tx_ready=0.
REQ-026 When the idle counter reaches TIMEOUT_CYCLES-1 while incrementing, SHALL go to IDLE, pulse timeout_pulse for that one cycle, and set the pointer to the other requester.
REQ-027 If a last-byte transfer and the timeout condition coincide, the transfer SHALL take precedence: the byte is accepted and timeout_pulse stays 0.
REQ-028 A return to IDLE SHALL take one cycle; re-arbitration happens in IDLE, so there are at least 2 cycles between a last byte and the next message's first transfer.
REQ-029 The block SHALL not inspect or alter byte contents; tx_data equals the owner's data bit-for-bit.
REQ-030 Each requester SHALL hold data, valid and last stable until ready; the arbiter SHALL not depend on requester behaviour beyond this.

Reset
REQ-031 Reset SHALL set the state to IDLE, owner=0, pointer=0 (requester 0 preferred), idle counter=0 and timeout_pulse=0.
REQ-032 While reset is asserted and on the first cycle after it, all outputs SHALL be: tx_valid=0, both ready=0, grant=00, timeout_pulse=0.
REQ-033 Reset mid-message SHALL abandon ownership immediately, with no transfer in the reset cycle.

Verification
REQ-034 After reset, both requesters valid at the same cycle, each sending a 1-byte last message (0x41 and 0x42), tx_ready=1 -> tx sequence 0x41 then 0x42; grant 01 then 10.
REQ-035 Requester 0 sends 3 bytes 0x10, 0x11, 0x12 (last on 0x12) while requester 1 is continuously valid -> tx shows 0x10, 0x11, 0x12 contiguous, then requester 1's byte; req1_ready=0 throughout requester 0's message.
REQ-036 tx_ready held 0 for 50 cycles with the owner valid (TIMEOUT_CYCLES=8) -> no timeout; the byte transfers when tx_ready rises.
REQ-037 Owner drops valid mid-message with TIMEOUT_CYCLES=8 -> timeout_pulse high for exactly 1 cycle, 8 cycles after entering LOCKED idle; grant=00 next cycle; the other requester is served next.
REQ-038 Reset asserted during byte 2 of a 4-byte message -> the next cycle shows all outputs at reset values; requester 0 wins the first arbitration after reset.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a UART transmitter.
// Whole messages are granted round-robin; an owner idle too long is dropped.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1_250_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       timeout_pulse
);

    localparam int CW = 25;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            own_valid;
    logic            own_last;
    logic [7:0]      own_data;
    logic            cnt_hit;

    assign own_valid = owner_q ? req1_valid : req0_valid;
    assign own_last  = owner_q ? req1_last  : req0_last;
    assign own_data  = owner_q ? req1_data  : req0_data;
    assign cnt_hit   = (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_d = LOCKED;
                    owner_d = (req0_valid && req1_valid) ? ptr_q : req1_valid;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                // A transfer always wins over the idle timeout.
                if (own_valid && tx_ready) begin
                    cnt_d = '0;
                    if (own_last) begin
                        state_d = IDLE;
                        ptr_d   = ~owner_q;
                    end
                end else if (!own_valid) begin
                    if (cnt_hit) begin
                        state_d = IDLE;
                        ptr_d   = ~owner_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held so nothing transfers.
    always_comb begin
        tx_data       = 8'h00;
        tx_valid      = 1'b0;
        grant         = 2'b00;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        timeout_pulse = 1'b0;
        if (!reset && state_q == LOCKED) begin
            tx_data       = own_data;
            tx_valid      = own_valid;
            grant         = owner_q ? 2'b10 : 2'b01;
            req0_ready    = !owner_q && tx_ready;
            req1_ready    = owner_q && tx_ready;
            timeout_pulse = !own_valid && cnt_hit;
        end
    end

endmodule
